// File: rtl/newton_pkg.sv
// Shared state encoding, error codes and display masks for the Newton
// root-finder control path.
package newton_pkg;

    typedef enum logic [2:0] {
        StGetA,
        StGetB,
        StGetC,
        StGetX,
        StCheck,
        StStep,
        StWait,
        StEmit
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_DEGEN   = 2'd1;
    localparam logic [1:0] ERR_ITER    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] AN_OK   = 8'hFE;
    localparam logic [7:0] AN_ERR  = 8'h00;
    localparam logic [7:0] AN_IDLE = 8'hFF;

endpackage

// File: rtl/step_watchdog.sv
// Saturating per-step cycle counter; expired_o flags that Limit-1 cycles have
// elapsed since the last clear.
module step_watchdog #(
    parameter int unsigned Limit = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned     CntW   = (Limit > 2) ? $clog2(Limit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Limit - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CntMax);

endmodule

// File: rtl/newton_sequencer.sv
// Control FSM: gathers a, b, c, x0 from the UART stream, steps the Newton
// solver under an iteration budget and watchdog, and hands back root or error.
module newton_sequencer
    import newton_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned MAX_ITER     = 32,
    parameter int unsigned STEP_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] slv_a,
    output logic [DATA_W-1:0] slv_b,
    output logic [DATA_W-1:0] slv_c,
    output logic [DATA_W-1:0] slv_x,
    output logic              slv_step,
    input  logic              slv_done,
    input  logic [DATA_W-1:0] slv_new_x,
    input  logic              slv_conv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_error,
    output logic [31:0]       disp_number,
    output logic [7:0]        disp_an_mask,
    output logic              busy
);

    localparam logic [7:0] MaxIter = 8'(MAX_ITER);

    state_e            state_d, state_q;
    logic [DATA_W-1:0] a_d, a_q, b_d, b_q, c_d, c_q, x_d, x_q;
    logic [7:0]        iter_d, iter_q;
    logic [1:0]        err_d, err_q;
    logic [31:0]       disp_number_d, disp_number_q;
    logic [7:0]        disp_an_mask_d, disp_an_mask_q;
    logic              wd_expired;

    step_watchdog #(
        .Limit (STEP_TIMEOUT)
    ) u_step_watchdog (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (state_q == StStep),
        .en_i      (state_q == StWait),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StGetA;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= '0;
            x_q            <= '0;
            iter_q         <= '0;
            err_q          <= ERR_OK;
            disp_number_q  <= '0;
            disp_an_mask_q <= AN_IDLE;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            c_q            <= c_d;
            x_q            <= x_d;
            iter_q         <= iter_d;
            err_q          <= err_d;
            disp_number_q  <= disp_number_d;
            disp_an_mask_q <= disp_an_mask_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        c_d            = c_q;
        x_d            = x_q;
        iter_d         = iter_q;
        err_d          = err_q;
        disp_number_d  = disp_number_q;
        disp_an_mask_d = disp_an_mask_q;
        unique case (state_q)
            StGetA: if (in_valid) begin a_d = in_data; state_d = StGetB; end
            StGetB: if (in_valid) begin b_d = in_data; state_d = StGetC; end
            StGetC: if (in_valid) begin c_d = in_data; state_d = StGetX; end
            StGetX: if (in_valid) begin x_d = in_data; state_d = StCheck; end
            StCheck: begin
                if ((a_q == '0) && (b_q == '0)) begin
                    err_d   = ERR_DEGEN;
                    state_d = StEmit;
                end else begin
                    iter_d  = '0;
                    state_d = StStep;
                end
            end
            StStep: state_d = StWait;
            StWait: begin
                // A result arriving on the timeout cycle still counts.
                if (slv_done) begin
                    x_d    = slv_new_x;
                    iter_d = iter_q + 8'd1;
                    if (slv_conv) begin
                        err_d   = ERR_OK;
                        state_d = StEmit;
                    end else if ((iter_q + 8'd1) == MaxIter) begin
                        err_d   = ERR_ITER;
                        state_d = StEmit;
                    end else begin
                        state_d = StStep;
                    end
                end else if (wd_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    disp_number_d  = 32'($signed(out_data));
                    disp_an_mask_d = (err_q == ERR_OK) ? AN_OK : AN_ERR;
                    state_d        = StGetA;
                end
            end
            default: state_d = StGetA;
        endcase
    end

    always_comb begin
        out_valid    = (state_q == StEmit);
        out_error    = out_valid ? err_q : ERR_OK;
        out_data     = (out_valid && (err_q == ERR_OK)) ? x_q : '0;
        slv_step     = (state_q == StStep);
        busy         = (state_q != StGetA);
        slv_a        = a_q;
        slv_b        = b_q;
        slv_c        = c_q;
        slv_x        = x_q;
        disp_number  = disp_number_q;
        disp_an_mask = disp_an_mask_q;
    end

endmodule

// File: tb/tb_newton_sequencer.sv
// Randomized bench for newton_sequencer: a scripted solver answers each step,
// and a plain-arithmetic model predicts step count, root, error and timing.
module tb_newton_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned MI = 4;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] slv_a, slv_b, slv_c, slv_x;
    logic          slv_step;
    logic          slv_done = 1'b0;
    logic [DW-1:0] slv_new_x = '0;
    logic          slv_conv = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_error;
    logic [31:0]   disp_number;
    logic [7:0]    disp_an_mask;
    logic          busy;

    newton_sequencer #(
        .DATA_W       (DW),
        .MAX_ITER     (MI),
        .STEP_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .slv_a        (slv_a),
        .slv_b        (slv_b),
        .slv_c        (slv_c),
        .slv_x        (slv_x),
        .slv_step     (slv_step),
        .slv_done     (slv_done),
        .slv_new_x    (slv_new_x),
        .slv_conv     (slv_conv),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_error    (out_error),
        .disp_number  (disp_number),
        .disp_an_mask (disp_an_mask),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [31:0]   prev_num = '0;
    logic [7:0]    prev_mask = 8'hFF;

    // Solver script: per step, latency to slv_done (0 = never), new_x, conv.
    int            plan_lat[MI];
    logic [DW-1:0] plan_x[MI];
    bit            plan_cv[MI];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Expected outcome straight from the solve rules.
    function automatic void ref_solve(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      output int steps, output logic [1:0] err,
                                      output logic [DW-1:0] root);
        steps = 0;
        err   = 2'd0;
        root  = '0;
        if (a == '0 && b == '0) begin
            err = 2'd1;
            return;
        end
        for (int i = 0; i < int'(MI); i++) begin
            steps = i + 1;
            if (plan_lat[i] == 0 || plan_lat[i] > int'(TO)) begin
                err = 2'd3;
                return;
            end
            if (plan_cv[i]) begin
                root = plan_x[i];
                return;
            end
        end
        err = 2'd2;
    endfunction

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        slv_done  = 1'b0;
        out_ready = 1'b0;
        tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_error", out_error, 0);
        check_eq("rst_slv_step", slv_step, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_disp_number", disp_number, 0);
        check_eq("rst_disp_mask", disp_an_mask, 8'hFF);
        check_eq("rst_slv_a", slv_a, 0);
        check_eq("rst_slv_x", slv_x, 0);
        reset     = 1'b1;
        prev_num  = '0;
        prev_mask = 8'hFF;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) tick();
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    // mode 0: full transaction; 1: reset in WAIT of step 1; 2: reset in EMIT.
    task automatic run_solve(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] c, input logic [DW-1:0] x0,
                             input int mode, input int hold);
        int            steps_exp, steps, c4, exp_vcyc, done_at, cur, step_cyc;
        logic [1:0]    err_exp;
        logic [DW-1:0] root_exp, cur_x;
        bit            got_valid;
        ref_solve(a, b, steps_exp, err_exp, root_exp);
        send_word(a);
        send_word(b);
        send_word(c);
        send_word(x0);
        c4        = cyc;
        steps     = 0;
        done_at   = -1;
        cur       = 0;
        step_cyc  = 0;
        cur_x     = x0;
        got_valid = 1'b0;
        exp_vcyc  = c4 + 1;
        for (int k = 0; k < 300; k++) begin
            tick();
            slv_done = 1'b0;
            if (out_valid) begin
                got_valid = 1'b1;
                break;
            end
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = DW'($urandom);
            if (slv_step) begin
                if (steps == 0) check_eq("first_step_cyc", cyc, c4 + 1);
                check_eq("slv_a", slv_a, a);
                check_eq("slv_b", slv_b, b);
                check_eq("slv_c", slv_c, c);
                check_eq("slv_x", slv_x, cur_x);
                if (steps < int'(MI)) begin
                    cur      = steps;
                    step_cyc = cyc;
                    done_at  = (plan_lat[cur] == 0) ? -1 : cyc + plan_lat[cur];
                    exp_vcyc = (plan_lat[cur] == 0 || plan_lat[cur] > int'(TO)) ?
                               cyc + int'(TO) + 1 : cyc + plan_lat[cur] + 1;
                end
                steps++;
            end
            if (mode == 1 && steps == 1 && cyc == step_cyc + 2) begin
                do_reset();
                return;
            end
            if (done_at == cyc) begin
                slv_done  = 1'b1;
                slv_new_x = plan_x[cur];
                slv_conv  = plan_cv[cur];
                cur_x     = plan_x[cur];
            end
        end
        slv_done = 1'b0;
        check_eq("valid_seen", got_valid, 1);
        if (!got_valid) begin
            do_reset();
            return;
        end
        check_eq("valid_cyc", cyc, exp_vcyc);
        check_eq("step_count", steps, steps_exp);
        check_eq("out_data", out_data, root_exp);
        check_eq("out_error", out_error, err_exp);
        check_eq("disp_hold", disp_number, prev_num);
        check_eq("mask_hold", disp_an_mask, prev_mask);
        if (mode == 2) begin
            repeat (3) tick();
            check_eq("emit_valid_pre_rst", out_valid, 1);
            do_reset();
            return;
        end
        for (int k = 0; k < hold; k++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = DW'($urandom);
            tick();
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, root_exp);
            check_eq("hold_error", out_error, err_exp);
        end
        out_ready = 1'b1;
        in_valid  = ($urandom_range(0, 1) == 0);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        prev_num  = {{(32 - DW){root_exp[DW-1]}}, root_exp};
        prev_mask = (err_exp == 2'd0) ? 8'hFE : 8'h00;
        check_eq("post_valid", out_valid, 0);
        check_eq("post_busy", busy, 0);
        check_eq("disp_number", disp_number, prev_num);
        check_eq("disp_mask", disp_an_mask, prev_mask);
    endtask

    task automatic plan_fixed(input int lat, input logic [DW-1:0] x, input bit cv_last, input int n);
        for (int i = 0; i < int'(MI); i++) begin
            plan_lat[i] = lat;
            plan_x[i]   = x + DW'(i);
            plan_cv[i]  = cv_last && (i == n - 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        do_reset();

        plan_lat = '{2, 3, 1, 4};
        plan_x   = '{16'd2, 16'd2, 16'd2, 16'd2};
        plan_cv  = '{1'b0, 1'b0, 1'b1, 1'b0};
        run_solve(16'd1, 16'd0, 16'hFFFC, 16'd3, 0, 0);

        run_solve(16'd0, 16'd0, 16'd5, 16'd1, 0, 10);

        plan_fixed(3, 16'h0100, 1'b0, 0);
        run_solve(16'd2, 16'd7, 16'd1, 16'd9, 0, 1);

        plan_fixed(0, 16'h0005, 1'b0, 0);
        run_solve(16'd3, 16'd1, 16'd2, 16'd4, 0, 2);

        plan_fixed(int'(TO), 16'h8007, 1'b1, 1);
        run_solve(16'd0, 16'd3, 16'd6, 16'd1, 0, 0);

        plan_fixed(10, 16'd2, 1'b1, 1);
        run_solve(16'd5, 16'd5, 16'd5, 16'd5, 1, 0);
        plan_lat = '{2, 3, 1, 4};
        plan_x   = '{16'd2, 16'd2, 16'd2, 16'd2};
        plan_cv  = '{1'b0, 1'b0, 1'b1, 1'b0};
        run_solve(16'd1, 16'd0, 16'hFFFC, 16'd3, 0, 0);

        plan_fixed(1, 16'hFFF0, 1'b1, 2);
        run_solve(16'd9, 16'd8, 16'd7, 16'd6, 2, 0);
        run_solve(16'd4, 16'd0, 16'd1, 16'd2, 0, 3);

        for (int t = 0; t < 20; t++) begin
            logic [DW-1:0] ra, rb;
            for (int i = 0; i < int'(MI); i++) begin
                int r = $urandom_range(0, 11);
                plan_lat[i] = (r < 9) ? $urandom_range(1, 6) : (r == 9) ? int'(TO) :
                              (r == 10) ? int'(TO) + 1 : 0;
                plan_x[i]   = DW'($urandom);
                plan_cv[i]  = ($urandom_range(0, 2) == 0);
            end
            ra = DW'($urandom);
            rb = DW'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                ra = '0;
                rb = '0;
            end
            run_solve(ra, rb, DW'($urandom), DW'($urandom), 0, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
